// File: rtl/dsp_console.sv
// Console byte stream to character-cell display bus master.
// Owns the cursor and performs CR/LF/BS/FF, auto-wrap, clear and hardware scroll.
module dsp_console #(
    parameter int ROWS = 30,
    parameter int COLS = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_attr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] dsp_addr,
    output logic        dsp_en,
    output logic        dsp_wr,
    input  logic        dsp_wt,
    output logic [15:0] dsp_wdata,
    input  logic [15:0] dsp_rdata,
    output logic [4:0]  cur_row,
    output logic [6:0]  cur_col,
    output logic        busy
);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_PUT,
        S_SC_RD,
        S_SC_WR,
        S_SC_BLANK,
        S_CLEAR
    } state_t;

    // A single-row screen has nothing to move, only the blank row to write.
    localparam state_t SCROLL_FIRST = (ROWS > 1) ? S_SC_RD : S_SC_BLANK;

    state_t      r_state, w_state_nx;
    logic [4:0]  r_row, w_row_nx, r_sr, w_sr_nx;
    logic [6:0]  r_col, w_col_nx, r_sc, w_sc_nx;
    logic [7:0]  r_attr, r_char;
    logic [15:0] r_cap;
    logic        w_accept, w_cap_en;

    assign in_ready = (r_state == S_IDLE) && !reset;
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state != S_IDLE);
    assign cur_row  = r_row;
    assign cur_col  = r_col;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_sr    <= '0;
            r_sc    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_row   <= w_row_nx;
            r_col   <= w_col_nx;
            r_sr    <= w_sr_nx;
            r_sc    <= w_sc_nx;
        end
    end

    // Byte latch and read capture are only observed after being loaded.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_attr <= in_attr;
            r_char <= in_data;
        end
        if (w_cap_en)
            r_cap <= dsp_rdata;
    end

    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        w_sr_nx    = r_sr;
        w_sc_nx    = r_sc;
        w_cap_en   = 1'b0;
        dsp_en     = 1'b0;
        dsp_wr     = 1'b0;
        dsp_addr   = '0;
        dsp_wdata  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nx = (in_data >= CH_SP) ? S_PUT : S_DECODE;
            end
            S_DECODE: begin
                w_state_nx = S_IDLE;
                case (r_char)
                    CH_CR: w_col_nx = '0;
                    CH_BS: begin
                        if (r_col != '0)
                            w_col_nx = r_col - 7'd1;
                    end
                    CH_LF: begin
                        if (r_row == LAST_ROW) begin
                            w_sr_nx    = 5'd1;
                            w_sc_nx    = '0;
                            w_state_nx = SCROLL_FIRST;
                        end else begin
                            w_row_nx = r_row + 5'd1;
                        end
                    end
                    CH_FF: begin
                        w_sr_nx    = '0;
                        w_sc_nx    = '0;
                        w_state_nx = S_CLEAR;
                    end
                    default: ;
                endcase
            end
            S_PUT: begin
                dsp_en     = 1'b1;
                dsp_wr     = 1'b1;
                dsp_addr   = {r_row, r_col};
                dsp_wdata  = {r_attr, r_char};
                w_state_nx = S_IDLE;
                if (r_col != LAST_COL) begin
                    w_col_nx = r_col + 7'd1;
                end else if (r_row != LAST_ROW) begin
                    w_col_nx = '0;
                    w_row_nx = r_row + 5'd1;
                end else begin
                    w_sr_nx    = 5'd1;
                    w_sc_nx    = '0;
                    w_state_nx = SCROLL_FIRST;
                end
            end
            S_SC_RD: begin
                // Address stays put until the display releases wait.
                dsp_en   = 1'b1;
                dsp_addr = {r_sr, r_sc};
                if (!dsp_wt) begin
                    w_cap_en   = 1'b1;
                    w_state_nx = S_SC_WR;
                end
            end
            S_SC_WR: begin
                dsp_en     = 1'b1;
                dsp_wr     = 1'b1;
                dsp_addr   = {r_sr - 5'd1, r_sc};
                dsp_wdata  = r_cap;
                w_state_nx = S_SC_RD;
                if (r_sc != LAST_COL) begin
                    w_sc_nx = r_sc + 7'd1;
                end else begin
                    w_sc_nx = '0;
                    if (r_sr == LAST_ROW)
                        w_state_nx = S_SC_BLANK;
                    else
                        w_sr_nx = r_sr + 5'd1;
                end
            end
            S_SC_BLANK: begin
                dsp_en    = 1'b1;
                dsp_wr    = 1'b1;
                dsp_addr  = {LAST_ROW, r_sc};
                dsp_wdata = {r_attr, CH_SP};
                if (r_sc != LAST_COL) begin
                    w_sc_nx = r_sc + 7'd1;
                end else begin
                    w_state_nx = S_IDLE;
                    w_row_nx   = LAST_ROW;
                    w_col_nx   = '0;
                end
            end
            S_CLEAR: begin
                dsp_en    = 1'b1;
                dsp_wr    = 1'b1;
                dsp_addr  = {r_sr, r_sc};
                dsp_wdata = {r_attr, CH_SP};
                if (r_sc != LAST_COL) begin
                    w_sc_nx = r_sc + 7'd1;
                end else begin
                    w_sc_nx = '0;
                    if (r_sr == LAST_ROW) begin
                        w_state_nx = S_IDLE;
                        w_row_nx   = '0;
                        w_col_nx   = '0;
                    end else begin
                        w_sr_nx = r_sr + 5'd1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end
endmodule

// File: doc/dsp_console.md
Name: dsp_console

Overview:
- Bus master that turns a byte stream (kernel/monitor console output) into character-cell writes on the text display slave port (row/column addressing, 16-bit cells, en/wr/wt handshake).
- Owns the cursor; handles CR, LF, BS, FF, auto-wrap, and hardware scroll by reading and rewriting cells through the display's read-wait handshake.
- Sits directly upstream of the display slave. Its dsp_* outputs connect straight to the display's addr/en/wr/data_in, and its dsp_wt/dsp_rdata inputs come from the display's wt/data_out.

Parameters:
ROWS, 30, visible text rows (1..32)
COLS, 80, visible text columns (1..128)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_data  in  8  byte to display
in_attr  in  8  attribute for this byte (cell bits 15:8), sampled with in_data
in_valid  in  1  byte offered
in_ready  out  1  byte accepted when in_valid & in_ready at a rising edge
dsp_addr  out  12  {row[4:0], col[6:0]}, maps to display addr[13:2]
dsp_en  out  1  bus cycle request
dsp_wr  out  1  1 = write, 0 = read
dsp_wt  in  1  display wait; honoured on reads only
dsp_wdata  out  16  {attr, char}
dsp_rdata  in  16  cell read data
cur_row  out  5  cursor row
cur_col  out  7  cursor column
busy  out  1  not in IDLE

Behaviour:
- Reset (async): state IDLE; cursor (0,0); dsp_en=0, dsp_wr=0, dsp_addr=0, dsp_wdata=0; in_ready=1 once reset deasserts; busy=0. Screen contents are not cleared. Reset mid-scroll or mid-clear aborts immediately, with no further bus cycles.
- in_ready is 1 only in IDLE. On acceptance, latch {in_attr, in_data} and leave IDLE on the next edge.
- Byte decode:
  - 0x20..0xFF: printable, go to PUT.
  - 0x0D CR: col=0.
  - 0x0A LF: row+1, or SCROLL if row=ROWS-1.
  - 0x08 BS: col-1 if col>0, else no change.
  - 0x0C FF: CLEAR, then cursor (0,0).
  - All other bytes are consumed with no effect.
  - CR, BS and ignored bytes take 1 cycle in a DECODE step; IDLE is re-entered the cycle after acceptance+1.
- PUT: a single cycle with dsp_en=1, dsp_wr=1, dsp_addr={row,col}, dsp_wdata={attr,char}; dsp_wt is ignored. Then advance the cursor:
  - col<COLS-1: col+1.
  - col=COLS-1: col=0 and row+1; if row was ROWS-1, enter SCROLL.
  - Latency: accept at edge N, write strobe during cycle N+1, in_ready=1 again in cycle N+2.
- Reads: hold dsp_en=1, dsp_wr=0 and a stable dsp_addr until a cycle with dsp_wt=0. Capture dsp_rdata in that cycle, and drop dsp_en or change the address on the following edge. With the current display each read takes 2 cycles; wait stretching of any length must work.
- SCROLL: for r=1..ROWS-1 and c=0..COLS-1 in row-major order:
  - Read (r,c), then write the captured value to (r-1,c).
  - Then write {latched attr, 8'h20} to every (ROWS-1,c).
  - Cursor ends at (ROWS-1, 0) for LF or wrap.
  - Total with 2-cycle reads: (ROWS-1)*COLS*3 + COLS cycles.
  - With ROWS=1 only the blank-row write occurs.
- CLEAR: write {latched attr, 8'h20} to all ROWS*COLS cells, one per cycle, row-major from (0,0).
- dsp_en is never asserted with row>=ROWS or col>=COLS. dsp_en=0 in IDLE and DECODE.
- Cursor invariant: row<ROWS and col<COLS at all times. cur_row/cur_col update on the edge that completes the operation.
- in_valid may drop without being accepted. Input is not consumed while busy.

Test Plan:
- Reset, send 'A' (0x41) with attr 0x07 → one cycle with dsp_en=1, dsp_wr=1, addr {5'd0,7'd0}, wdata 0x0741, exactly one cycle after acceptance; cursor (0,1); in_ready back after 2 cycles.
- ROWS=4, COLS=8: fill the screen with 32 printable bytes, then send one more 'Z' → the 33rd write lands at (3,0). Check the cell model: rows 0..2 hold old rows 1..3 shifted; row 3 is 0x0720 blanks except 'Z' at (3,0).
- Bench display model with variable wt stretching (0..5 extra cycles) during scroll → every read holds en/addr stable until wt=0; the final cell image is identical to the no-stretch run.
- Send FF with attr 0x1F (ROWS=4, COLS=8) → 32 consecutive writes of 0x1F20 covering all addresses once; busy for 32+1 cycles; cursor (0,0).
- From (2,5): send BS, BS, CR, BS, LF, then 0x01 → cursor (2,4), (2,3), (2,0), (2,0), (3,0), (3,0); no bus writes.
- Assert reset mid-scroll → dsp_en drops asynchronously; cursor (0,0); afterwards 'B' writes to (0,0).
